// File: rtl/register_dump_unit.sv
// Debug register dump: walks every register on the debug read port and streams each
// captured word out as bytes, MSB first, over a valid/ready byte interface.
module register_dump_unit #(
  parameter int unsigned BITS_REGS = 5,
  parameter int unsigned BITS_SIZE = 32,
  parameter int unsigned REG_SIZE  = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_start,
  input  logic [BITS_SIZE-1:0] i_reg_data,
  input  logic                 i_tx_ready,
  output logic [BITS_REGS-1:0] o_reg_addr,
  output logic [7:0]           o_tx_data,
  output logic                 o_tx_valid,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int unsigned BYTES = BITS_SIZE / 8;
  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0]     LAST_BYTE = IDX_W'(BYTES - 1);
  localparam logic [BITS_REGS-1:0] LAST_ADDR = BITS_REGS'(REG_SIZE - 1);

  typedef enum logic [2:0] {StIdle, StSetup, StSend, StNext, StDone} state_e;

  state_e                r_state, w_state_d;
  logic [BITS_REGS-1:0]  r_addr, w_addr_d;
  logic [BITS_SIZE-1:0]  r_word, w_word_d;
  logic [IDX_W-1:0]      r_byte_idx, w_byte_idx_d;
  logic [BITS_SIZE-1:0]  w_word_sh;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= StIdle;
      r_addr     <= '0;
      r_word     <= '0;
      r_byte_idx <= '0;
    end else begin
      r_state    <= w_state_d;
      r_addr     <= w_addr_d;
      r_word     <= w_word_d;
      r_byte_idx <= w_byte_idx_d;
    end
  end

  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_word_d     = r_word;
    w_byte_idx_d = r_byte_idx;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_addr_d  = '0;
          w_state_d = StSetup;
        end
      end
      StSetup: begin
        w_word_d     = i_reg_data;
        w_byte_idx_d = '0;
        w_state_d    = StSend;
      end
      StSend: begin
        // Valid is asserted for the whole state, so ready alone completes the handshake.
        if (i_tx_ready) begin
          if (r_byte_idx == LAST_BYTE) begin
            w_state_d = StNext;
          end else begin
            w_byte_idx_d = r_byte_idx + IDX_W'(1);
          end
        end
      end
      StNext: begin
        if (r_addr == LAST_ADDR) begin
          w_state_d = StDone;
        end else begin
          w_addr_d  = r_addr + BITS_REGS'(1);
          w_state_d = StSetup;
        end
      end
      StDone: begin
        w_addr_d  = '0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Shift the selected byte to the top of the word so the slice base stays constant.
  assign w_word_sh  = r_word << {r_byte_idx, 3'b000};
  assign o_tx_data  = (r_state == StSend) ? w_word_sh[BITS_SIZE-1 -: 8] : 8'h00;
  assign o_tx_valid = (r_state == StSend);
  assign o_busy     = (r_state != StIdle);
  assign o_done     = (r_state == StDone);
  assign o_reg_addr = r_addr;

endmodule

// File: tb/tb_register_dump_unit.sv
// Self-checking bench for register_dump_unit: randomized register contents and backpressure
// checked against a byte-stream model built directly from the register array.
module tb_register_dump_unit;

  logic        clk;
  logic        i_reset;
  logic        i_start;
  logic        i_tx_ready;
  logic [31:0] i_reg_data;
  logic [4:0]  o_reg_addr;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_busy;
  logic        o_done;

  logic        s16_start;
  logic        s16_ready;
  logic [15:0] s16_reg_data;
  logic [4:0]  s16_addr;
  logic [7:0]  s16_tx_data;
  logic        s16_tx_valid;
  logic        s16_busy;
  logic        s16_done;

  logic [31:0] mem [32];
  int n_vec = 0;
  int n_err = 0;

  assign i_reg_data   = mem[o_reg_addr];
  assign s16_reg_data = {11'b0, s16_addr};

  register_dump_unit dut (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (i_start),
    .i_reg_data (i_reg_data),
    .i_tx_ready (i_tx_ready),
    .o_reg_addr (o_reg_addr),
    .o_tx_data  (o_tx_data),
    .o_tx_valid (o_tx_valid),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  register_dump_unit #(.BITS_REGS(5), .BITS_SIZE(16), .REG_SIZE(8)) dut16 (
    .i_clk      (clk),
    .i_reset    (i_reset),
    .i_start    (s16_start),
    .i_reg_data (s16_reg_data),
    .i_tx_ready (s16_ready),
    .o_reg_addr (s16_addr),
    .o_tx_data  (s16_tx_data),
    .o_tx_valid (s16_tx_valid),
    .o_busy     (s16_busy),
    .o_done     (s16_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_start = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if (o_busy !== 1'b0 || o_tx_valid !== 1'b0 || o_done !== 1'b0 || o_reg_addr !== 5'd0) begin
        n_err++;
        $display("FAIL reset: busy=%b valid=%b done=%b addr=%0d, required 0 0 0 0",
                 o_busy, o_tx_valid, o_done, o_reg_addr);
      end
    end
    i_reset = 1'b0;
    i_start = 1'b0;
    tick();
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_no_start: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_full_dump();
    logic [7:0] got[$];
    logic [7:0] exp[$];
    logic [7:0] g;
    int done_cnt = 0;
    int done_cyc = -1;
    for (int r = 0; r < 32; r++) mem[r] = r;
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++) exp.push_back(8'((mem[r] >> (8 * (3 - b))) & 32'hFF));
    i_tx_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int c = 1; c <= 200; c++) begin
      if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
      if (o_done) begin
        done_cnt++;
        done_cyc = c;
      end
      n_vec++;
      if (o_busy !== (c <= 193)) begin
        n_err++;
        $display("FAIL full_busy cycle %0d: got %b, required %b", c, o_busy, (c <= 193));
      end
      tick();
    end
    n_vec++;
    if (done_cnt != 1 || done_cyc != 193) begin
      n_err++;
      $display("FAIL full_done: %0d pulses at cycle %0d, required 1 at 193", done_cnt, done_cyc);
    end
    n_vec++;
    if (got.size() != 128) begin
      n_err++;
      $display("FAIL full_count: got %0d bytes, required 128", got.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (g !== exp[i]) begin
        n_err++;
        $display("FAIL full_byte %0d: got %h, required %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got[$];
    logic [7:0] exp[$];
    logic [7:0] g;
    int  stall_cnt = 0;
    bit  stalled = 0;
    bit  done_seen = 0;
    int  cyc = 0;
    for (int r = 0; r < 32; r++) mem[r] = $urandom;
    mem[0] = 32'hDEADBEEF;
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++) exp.push_back(8'((mem[r] >> (8 * (3 - b))) & 32'hFF));
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (!done_seen && cyc < 3000) begin
      if (!stalled && o_tx_valid && o_reg_addr == 5'd0 && o_tx_data == 8'hAD) begin
        stalled = 1;
        stall_cnt = 3;
      end
      if (stall_cnt > 0) begin
        i_tx_ready = 1'b0;
        stall_cnt--;
        n_vec++;
        if (o_tx_valid !== 1'b1 || o_tx_data !== 8'hAD) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b data=%h, required 1 ad", o_tx_valid, o_tx_data);
        end
      end else begin
        i_tx_ready = ($urandom_range(0, 3) != 0);
      end
      if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
      if (o_done) done_seen = 1;
      tick();
      cyc++;
    end
    i_tx_ready = 1'b1;
    n_vec++;
    if (!done_seen || !stalled) begin
      n_err++;
      $display("FAIL bp_timeout: done=%b stalled=%b, required 1 1", done_seen, stalled);
    end
    n_vec++;
    if (got.size() != 128) begin
      n_err++;
      $display("FAIL bp_count: got %0d bytes, required 128", got.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (g !== exp[i]) begin
        n_err++;
        $display("FAIL bp_byte %0d: got %h, required %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_start_busy();
    logic [7:0] got[$];
    int done_cnt = 0;
    bit order_ok = 1;
    for (int r = 0; r < 32; r++) mem[r] = r;
    i_tx_ready = 1'b1;
    i_start = 1'b1;
    tick();
    for (int c = 1; c <= 260; c++) begin
      i_start = (c == 10 || c == 50);
      if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
      if (o_done) done_cnt++;
      tick();
    end
    i_start = 1'b0;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== ((i % 4 == 3) ? 8'(i / 4) : 8'h00)) order_ok = 0;
    n_vec++;
    if (done_cnt != 1 || got.size() != 128 || !order_ok) begin
      n_err++;
      $display("FAIL start_busy: done=%0d bytes=%0d order=%b, required 1 128 1",
               done_cnt, got.size(), order_ok);
    end
    n_vec++;
    if (o_busy !== 1'b0) begin
      n_err++;
      $display("FAIL start_busy_idle: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got[$];
    logic [7:0] exp[$];
    logic [7:0] g;
    int  cyc = 0;
    bit  done_seen = 0;
    for (int r = 0; r < 32; r++) mem[r] = $urandom;
    for (int r = 0; r < 32; r++)
      for (int b = 0; b < 4; b++) exp.push_back(8'((mem[r] >> (8 * (3 - b))) & 32'hFF));
    i_tx_ready = 1'b1;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (!(o_tx_valid && o_reg_addr == 5'd5) && cyc < 100) begin
      tick();
      cyc++;
    end
    n_vec++;
    if (cyc >= 100) begin
      n_err++;
      $display("FAIL rst_mid_reach: never saw SEND of register 5 (addr=%0d)", o_reg_addr);
    end
    i_reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_vec++;
      if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_reg_addr !== 5'd0 || o_done !== 1'b0) begin
        n_err++;
        $display("FAIL rst_mid: valid=%b busy=%b addr=%0d done=%b, required 0 0 0 0",
                 o_tx_valid, o_busy, o_reg_addr, o_done);
      end
    end
    i_reset = 1'b0;
    tick();
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n_vec++;
    if (o_busy !== 1'b1 || o_reg_addr !== 5'd0) begin
      n_err++;
      $display("FAIL rst_restart: busy=%b addr=%0d, required 1 0", o_busy, o_reg_addr);
    end
    cyc = 0;
    while (!done_seen && cyc < 3000) begin
      i_tx_ready = ($urandom_range(0, 1) != 0);
      if (o_tx_valid && i_tx_ready) got.push_back(o_tx_data);
      if (o_done) done_seen = 1;
      tick();
      cyc++;
    end
    i_tx_ready = 1'b1;
    n_vec++;
    if (!done_seen || got.size() != 128) begin
      n_err++;
      $display("FAIL rst_redump: done=%b bytes=%0d, required 1 128", done_seen, got.size());
    end
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      n_vec++;
      if (g !== exp[i]) begin
        n_err++;
        $display("FAIL rst_redump_byte %0d: got %h, required %h", i, g, exp[i]);
      end
    end
  endtask

  task automatic test_variant16();
    logic [7:0] got[$];
    logic [7:0] g;
    logic [7:0] e;
    int done_cnt = 0;
    int done_cyc = -1;
    s16_ready = 1'b1;
    s16_start = 1'b1;
    tick();
    s16_start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (s16_tx_valid && s16_ready) got.push_back(s16_tx_data);
      if (s16_done) begin
        done_cnt++;
        done_cyc = c;
      end
      n_vec++;
      if (s16_busy !== (c <= 33)) begin
        n_err++;
        $display("FAIL v16_busy cycle %0d: got %b, required %b", c, s16_busy, (c <= 33));
      end
      tick();
    end
    n_vec++;
    if (done_cnt != 1 || done_cyc != 33 || got.size() != 16) begin
      n_err++;
      $display("FAIL v16_done: %0d pulses at %0d, %0d bytes, required 1 at 33, 16 bytes",
               done_cnt, done_cyc, got.size());
    end
    for (int i = 0; i < 16; i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      e = (i % 2 == 1) ? 8'(i / 2) : 8'h00;
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL v16_byte %0d: got %h, required %h", i, g, e);
      end
    end
  endtask

  initial begin
    i_reset    = 1'b1;
    i_start    = 1'b0;
    i_tx_ready = 1'b1;
    s16_start  = 1'b0;
    s16_ready  = 1'b1;
    for (int r = 0; r < 32; r++) mem[r] = '0;
    test_reset();
    test_full_dump();
    test_backpressure();
    tick();
    test_start_busy();
    test_reset_mid();
    tick();
    test_variant16();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_dump_unit.md
Name: register_dump_unit

Overview:
- Debug-side consumer of the register file's debug read port.
- On a start pulse, walks every register address on o_reg_addr and captures the returned word from i_reg_data.
- Serializes each word into bytes, MSB first, over a valid/ready byte stream feeding the debug UART transmitter.
- Used by the debug controller to dump processor state while the pipeline is halted (step inactive).

Parameters:
- BITS_REGS, 5, width of register address.
- BITS_SIZE, 32, width of register data word; must be a multiple of 8.
- REG_SIZE, 32, number of registers dumped; must be at most 2**BITS_REGS and at least 1.

Ports:
- i_clk  in  1  clock; all state updates on posedge.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  begin dump; sampled only in IDLE.
- i_reg_data  in  BITS_SIZE  debug read data from register file, combinational in o_reg_addr.
- i_tx_ready  in  1  UART TX can accept a byte this cycle.
- o_reg_addr  out  BITS_REGS  debug read address to register file; registered.
- o_tx_data  out  8  byte to transmit.
- o_tx_valid  out  1  o_tx_data is valid.
- o_busy  out  1  high in every state except IDLE.
- o_done  out  1  one-cycle pulse when the dump completes.

Behaviour:
- Local parameter BYTES = BITS_SIZE/8.
- Internal registers:
  - word_q, BITS_SIZE bits: captured register word.
  - byte_idx, clog2(BYTES) bits, minimum 1.
  - addr_q, drives o_reg_addr.
  - state.
- Reset, taking effect at the first posedge with i_reset=1:
  - state=IDLE; addr_q=0, word_q=0, byte_idx=0.
  - o_tx_valid=0, o_busy=0, o_done=0, o_tx_data=0.
  - Reset overrides every other input, including mid-dump; no further bytes are emitted.
- States:
  - IDLE: o_busy=0. If i_start=1: addr_q<=0, go to SETUP. Otherwise stay.
  - SETUP: o_reg_addr is stable. At the closing edge: word_q<=i_reg_data, byte_idx<=0, go to SEND.
  - SEND: o_tx_valid=1; o_tx_data=word_q[BITS_SIZE-1-8*byte_idx -: 8] (MSB byte first).
    - Handshake completes on a cycle with o_tx_valid & i_tx_ready.
    - On completion with byte_idx==BYTES-1: go to NEXT. Otherwise byte_idx<=byte_idx+1 and stay.
    - While i_tx_ready=0, o_tx_data and o_tx_valid hold unchanged.
  - NEXT: o_tx_valid=0. If addr_q==REG_SIZE-1, go to DONE. Otherwise addr_q<=addr_q+1, go to SETUP.
  - DONE: o_done=1 for exactly this cycle, o_busy=1. Then go to IDLE with addr_q<=0.
- o_tx_valid, o_done and o_busy are decoded from the registered state; no combinational path from i_tx_ready to any output.
- i_start while not in IDLE is ignored. No queued restart.
- i_start held high across DONE→IDLE starts a new dump in the cycle after IDLE is entered.
- Timing with i_tx_ready held at 1 (start sampled at edge 0):
  - Register k: SETUP in cycle 1+6k, bytes in cycles 2+6k .. 5+6k, NEXT in cycle 6+6k.
  - DONE in cycle 6*REG_SIZE+1; IDLE from cycle 6*REG_SIZE+2.
- Address wraps nowhere: addr_q never exceeds REG_SIZE-1.
- Snapshot consistency requires the register file write enable to be inactive during the dump. This is the debug controller's responsibility; this unit does not check it.

Test Plan:
- Reset: assert i_reset 2 cycles with i_start=1 → o_busy=0, o_tx_valid=0, o_done=0, o_reg_addr=0; no dump starts while reset is asserted.
- Full dump, i_tx_ready=1, register model returning data=address:
  - Exactly 128 handshakes, sequence 00 00 00 00, 00 00 00 01, …, 00 00 00 1F.
  - o_done single pulse in cycle 193 after the start edge; o_busy high in cycles 1..193.
- Backpressure: model returns 0xDEADBEEF for address 0; drop i_tx_ready for 3 cycles while byte 0xAD is presented → o_tx_data stays 0xAD with o_tx_valid=1 across the stall; byte order DE AD BE EF; no byte duplicated or lost.
- Start while busy: pulse i_start at cycles 10 and 50 of a dump → single dump of 128 bytes; o_done pulses once.
- Reset mid-dump: assert i_reset during SEND of register 5 → next cycle o_tx_valid=0, o_busy=0, o_reg_addr=0. A new i_start restarts from register 0, first byte 00.
- Parameter variant BITS_SIZE=16, REG_SIZE=8, data=address → 16 bytes 00 00, 00 01, …, 00 07; o_done in cycle 4*8+1=33.
